tanh_pwl_stream: RTL and testbench



---
 rtl/tanh_pwl_pkg.sv | 33 +++
 rtl/tanh_pwl_lane.sv | 43 ++++
 rtl/tanh_pwl_stream.sv | 131 +++++++++++++
 tb/tb_tanh_pwl_stream.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pwl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tanh_pwl_pkg
// Brief    : Mode encoding and WIDTH-derived breakpoints for the tanh unit.
// Revision : 1.0 - initial release
// ============================================================================
package tanh_pwl_pkg;

    typedef enum logic {
        TANH_MODE_PWL  = 1'b0,
        TANH_MODE_HARD = 1'b1
    } tanh_mode_e;

    // 0.5 in the Q2.(WIDTH-2) input format
    function automatic int tanh_half(input int width);
        return 1 << (width - 3);
    endfunction

    function automatic int tanh_thresh(input int width);
        return 3 * tanh_half(width);
    endfunction

    function automatic int tanh_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // 0.25 in the Q1.(WIDTH-1) output format
    function automatic int tanh_offset(input int width);
        return 1 << (width - 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tanh_pwl_lane.sv
`default_nettype none
// ============================================================================
// Module   : tanh_pwl_lane
// Brief    : Combinational |x| -> |y| mapping for one lane (PWL or hard tanh).
// Revision : 1.0 - initial release
// ============================================================================
module tanh_pwl_lane
    import tanh_pwl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_mag,
    input  tanh_mode_e       i_mode,
    output logic [WIDTH-1:0] o_y
);

    localparam logic [WIDTH:0] c_half   = (WIDTH+1)'(tanh_half(WIDTH));
    localparam logic [WIDTH:0] c_thresh = (WIDTH+1)'(tanh_thresh(WIDTH));
    localparam logic [WIDTH:0] c_max    = (WIDTH+1)'(tanh_max(WIDTH));
    localparam logic [WIDTH:0] c_offset = (WIDTH+1)'(tanh_offset(WIDTH));

    logic [WIDTH:0] w_mag;
    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_raw;

    // One extra bit so |-2.0| doubled does not wrap before the clamp
    assign w_mag = {1'b0, i_mag};
    assign w_dbl = {i_mag, 1'b0};

    always_comb begin
        w_raw = c_max;
        if (i_mode == TANH_MODE_HARD) begin
            w_raw = w_dbl;
        end else if (w_mag < c_half) begin
            w_raw = w_dbl;
        end else if (w_mag < c_thresh) begin
            w_raw = w_mag + c_offset;
        end
        o_y = (w_raw > c_max) ? c_max[WIDTH-1:0] : w_raw[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/tanh_pwl_stream.sv
`default_nettype none
// ============================================================================
// Module   : tanh_pwl_stream
// Brief    : 3-stage streaming tanh unit, CHANNELS lanes, valid/ready both
//            sides. Define TANH_PWL_SAT_STATS_EN to add the sat_count port.
// Revision : 1.0 - initial release
// ============================================================================
module tanh_pwl_stream
    import tanh_pwl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef TANH_PWL_SAT_STATS_EN
    ,
    output logic [31:0]               sat_count
`endif
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(tanh_max(WIDTH));

    logic                           w_adv;
    logic [CHANNELS-1:0]            w_sign;
    logic [CHANNELS-1:0][WIDTH-1:0] w_abs;
    logic [CHANNELS-1:0][WIDTH-1:0] w_lane_y;
    logic [CHANNELS-1:0][WIDTH-1:0] w_out;

    logic                           r_s1_valid;
    tanh_mode_e                     r_s1_mode;
    logic [CHANNELS-1:0]            r_s1_sign;
    logic [CHANNELS-1:0][WIDTH-1:0] r_s1_mag;

    logic                           r_s2_valid;
    logic [CHANNELS-1:0]            r_s2_sign;
    logic [CHANNELS-1:0][WIDTH-1:0] r_s2_mag;

    logic                           r_s3_valid;
    logic [CHANNELS-1:0][WIDTH-1:0] r_s3_data;

    // Whole pipeline moves in lock-step; bubbles are kept, not squeezed out
    assign w_adv     = ~r_s3_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s3_valid;
    assign out_data  = r_s3_data;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [WIDTH-1:0] w_x;

        assign w_x       = in_data[k*WIDTH +: WIDTH];
        assign w_sign[k] = w_x[WIDTH-1];
        assign w_abs[k]  = w_x[WIDTH-1] ? -w_x : w_x;

        tanh_pwl_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .i_mag  (r_s1_mag[k]),
            .i_mode (r_s1_mode),
            .o_y    (w_lane_y[k])
        );

        assign w_out[k] = r_s2_sign[k] ? -r_s2_mag[k] : r_s2_mag[k];
    end : g_lane

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= TANH_MODE_PWL;
            r_s1_sign  <= '0;
            r_s1_mag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= '0;
            r_s2_mag   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (in_valid) begin
                r_s1_mode <= tanh_mode_e'(in_mode);
                r_s1_sign <= w_sign;
                r_s1_mag  <= w_abs;
            end
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_mag  <= w_lane_y;
            end
            if (r_s2_valid) begin
                r_s3_data <= w_out;
            end
        end
    end

`ifdef TANH_PWL_SAT_STATS_EN
    logic [31:0] r_sat_count;
    logic [31:0] w_sat_inc;
    logic [32:0] w_sat_sum;

    always_comb begin
        w_sat_inc = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_s2_mag[k] == c_max) begin
                w_sat_inc = w_sat_inc + 32'd1;
            end
        end
        w_sat_sum = {1'b0, r_sat_count} + {1'b0, w_sat_inc};
    end

    // Counted as the beat leaves S2, so a held beat is counted exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (w_adv && r_s2_valid) begin
            r_sat_count <= w_sat_sum[32] ? '1 : w_sat_sum[31:0];
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tanh_pwl_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_pwl_stream
// Brief    : Self-checking bench for tanh_pwl_stream (WIDTH=8, CHANNELS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_pwl_stream;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int DW = W * CH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef TANH_PWL_SAT_STATS_EN
    logic [31:0]   sat_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tanh_pwl_stream #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef TANH_PWL_SAT_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    // Real-valued tanh approximation, scaled to the Q1.(W-1) output grid
    function automatic logic [DW-1:0] ref_beat(input logic mode, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic [W-1:0]  lane;
        real           xr;
        real           ar;
        real           yr;
        int            yi;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            lane = d[k*W +: W];
            xr   = real'($signed(lane)) / real'(1 << (W - 2));
            ar   = (xr < 0.0) ? -xr : xr;
            if (mode) yr = (ar > 1.0) ? 1.0 : ar;
            else if (ar < 0.5) yr = ar;
            else if (ar < 1.5) yr = ar / 2.0 + 0.25;
            else yr = 1.0;
            yi = int'(yr * real'(1 << (W - 1)));
            if (yi > (1 << (W - 1)) - 1) yi = (1 << (W - 1)) - 1;
            if (xr < 0.0) yi = -yi;
            r[k*W +: W] = W'(yi);
        end
        return r;
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic stale;
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h10401040;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL midreset_data: got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_after_reset: got %b want 0", stale); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pwl_values();
        idle(2);
        in_valid = 1'b1; in_mode = 1'b0; in_data = {8'h80, 8'hC0, 8'h40, 8'h10};
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pwl_early_valid: got %b want 0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pwl_valid: got %b want 1", out_valid); end
        total++; if (out_data !== {8'h81, 8'hA0, 8'h60, 8'h20}) begin
            bad++; $display("FAIL pwl_data: got %h want %h", out_data, {8'h81, 8'hA0, 8'h60, 8'h20});
        end
    endtask

    task automatic test_hard_mode();
        logic          md [2];
        logic [DW-1:0] din[2];
        logic [DW-1:0] exp_d[2];
        md[0] = 1'b1; din[0] = {8'h7F, 8'hF0, 8'h40, 8'h10}; exp_d[0] = {8'h7F, 8'hE0, 8'h7F, 8'h20};
        md[1] = 1'b0; din[1] = {8'h80, 8'hC0, 8'h40, 8'h10}; exp_d[1] = {8'h81, 8'hA0, 8'h60, 8'h20};
        idle(2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mode = md[i]; in_data = din[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                bad++; $display("FAIL mode_mix_%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, exp_d[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundaries();
        logic          md [3];
        logic [DW-1:0] din[3];
        logic [DW-1:0] exp_d[3];
        md[0] = 1'b0; din[0] = {8'h60, 8'h5F, 8'h20, 8'h1F}; exp_d[0] = {8'h7F, 8'h7F, 8'h40, 8'h3E};
        md[1] = 1'b0; din[1] = '0;                            exp_d[1] = '0;
        md[2] = 1'b1; din[2] = {8'h80, 8'hE0, 8'h20, 8'h00}; exp_d[2] = {8'h81, 8'hC0, 8'h40, 8'h00};
        idle(2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = md[i]; in_data = din[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                bad++; $display("FAIL boundary_%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, exp_d[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q[$];
        logic [DW-1:0] held;
        logic [DW-1:0] exp_d;
        int            acc;
        int            recv;
        logic          take_new;
        idle(4);
        acc = 0; recv = 0; take_new = 1'b1; held = '0;
        for (int c = 0; c < 16; c++) begin
            if (take_new) begin
                in_valid = 1'b1; in_data = $urandom; in_mode = 1'($urandom_range(0, 1));
            end
            out_ready = !(c >= 6 && c < 11);
            #1;
            if (!out_ready) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                if (c == 6) begin
                    held = out_data;
                    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_full: got %b want 1", out_valid); end
                end else begin
                    total++; if (out_valid !== 1'b1 || out_data !== held) begin
                        bad++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", out_valid, out_data, held);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL bp_extra: got %h want none", out_data); end
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin bad++; $display("FAIL bp_order: got %h want %h", out_data, exp_d); end
                end
                recv++;
            end
            take_new = (in_ready === 1'b1);
            if (in_ready === 1'b1) begin
                q.push_back(ref_beat(in_mode, in_data));
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL bp_dup: got %h want none", out_data); end
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin bad++; $display("FAIL bp_drain: got %h want %h", out_data, exp_d); end
                end
                recv++;
            end
            @(negedge clk);
        end
        total++; if (q.size() != 0 || recv != acc) begin
            bad++; $display("FAIL bp_count: got recv=%0d left=%0d want recv=%0d left=0", recv, q.size(), acc);
        end
    endtask

    task automatic test_random_scoreboard();
        localparam int N = 10000;
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] prev_data;
        int            sent;
        int            recv;
        int            cyc;
        logic          take_new;
        logic          prev_stall;
        idle(4);
        sent = 0; recv = 0; cyc = 0; take_new = 1'b1; prev_stall = 1'b0; prev_data = '0;
        while (recv < N && cyc < 60000) begin
            if (take_new) begin
                if (sent < N && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1; in_data = $urandom; in_mode = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                total++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    bad++; $display("FAIL rnd_hold: got v=%b %h want v=1 %h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_extra: got %h want none", out_data); end
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin bad++; $display("FAIL rnd_data: got %h want %h", out_data, exp_d); end
                end
                recv++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            take_new   = 1'b1;
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(ref_beat(in_mode, in_data));
                sent++;
            end else if (in_valid) begin
                take_new = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv != N || q.size() != 0) begin
            bad++; $display("FAIL rnd_count: got recv=%0d left=%0d want recv=%0d left=0", recv, q.size(), N);
        end
    endtask

`ifdef TANH_PWL_SAT_STATS_EN
    task automatic test_sat_count();
        int          acc;
        logic        prev_stall;
        logic [31:0] prev_cnt;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (sat_count !== 32'd0) begin bad++; $display("FAIL sat_reset: got %0d want 0", sat_count); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = {4{8'h7F}};
            @(negedge clk);
        end
        idle(5);
        total++; if (sat_count !== 32'd40) begin bad++; $display("FAIL sat_ten_beats: got %0d want 40", sat_count); end
        acc = 0; prev_stall = 1'b0; prev_cnt = '0;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = {4{8'h7F}};
        for (int c = 0; c < 8; c++) begin
            #1;
            if (prev_stall) begin
                total++; if (sat_count !== prev_cnt) begin
                    bad++; $display("FAIL sat_stall: got %0d want %0d", sat_count, prev_cnt);
                end
            end
            prev_stall = (out_valid === 1'b1);
            prev_cnt   = sat_count;
            if (in_ready === 1'b1) acc++;
            @(negedge clk);
        end
        idle(6);
        total++; if (sat_count !== 32'(40 + 4 * acc)) begin
            bad++; $display("FAIL sat_final: got %0d want %0d", sat_count, 40 + 4 * acc);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_pwl_values();
        test_hard_mode();
        test_boundaries();
        test_backpressure();
        test_random_scoreboard();
`ifdef TANH_PWL_SAT_STATS_EN
        test_sat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
